// File: rtl/streamselect_arb.sv
// Message-granular arbiter that merges NUM_STREAMS sources onto one tx stream port.
// The grant is held for a whole message. Either round-robin or fixed-priority arbitration is selected by parameter.
module streamselect_arb #(
   parameter int unsigned NUM_STREAMS = 4,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned COUNT_W     = 8,
   parameter int unsigned ROUND_ROBIN = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_STREAMS*DATA_W-1:0]  in_data,
   input  logic [NUM_STREAMS*COUNT_W-1:0] in_count,
   input  logic [NUM_STREAMS-1:0]         in_avail,
   output logic [NUM_STREAMS-1:0]         in_pull,
   output logic [DATA_W-1:0]              strm_data,
   output logic [COUNT_W-1:0]             strm_count,
   output logic [3:0]                     strm_id,
   output logic                           strm_avail,
   input  logic                           strm_pull
);

   localparam int unsigned ID_W  = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
   localparam int unsigned REM_W = COUNT_W + 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_STREAMS - 1);

   // strm_id is fixed at 4 bits, so at most 16 channels can be encoded
   generate
      if (NUM_STREAMS < 2 || NUM_STREAMS > 16) begin : g_bad_num_streams
         $error("streamselect_arb: NUM_STREAMS must be in 2..16");
      end
   endgenerate

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [ID_W-1:0]   grant;
   logic [ID_W-1:0]   grant_nxt;
   logic [ID_W-1:0]   last_grant;
   logic [ID_W-1:0]   last_nxt;
   logic [REM_W-1:0]  remaining;
   logic [REM_W-1:0]  rem_nxt;
   logic [COUNT_W-1:0] count_nxt;

   logic [ID_W-1:0]   winner_c;
   logic [ID_W-1:0]   cand_c;
   logic              found_c;

   logic [DATA_W-1:0]  data_arr  [NUM_STREAMS];
   logic [COUNT_W-1:0] count_arr [NUM_STREAMS];

   for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_unpack
      assign data_arr[g]  = in_data[g*DATA_W +: DATA_W];
      assign count_arr[g] = in_count[g*COUNT_W +: COUNT_W];
   end

   // Winner search: rotate the scan start to last_grant+1 in round-robin mode
   always_comb begin
      winner_c = '0;
      cand_c   = '0;
      found_c  = 1'b0;
      for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
         if (ROUND_ROBIN != 0) begin
            cand_c = ID_W'((32'(last_grant) + i + 32'd1) % NUM_STREAMS);
         end else begin
            cand_c = ID_W'(i);
         end
         if (!found_c && in_avail[cand_c]) begin
            winner_c = cand_c;
            found_c  = 1'b1;
         end
      end
   end

   // Next-state and pull/avail decode
   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
      last_nxt   = last_grant;
      rem_nxt    = remaining;
      count_nxt  = strm_count;
      strm_avail = 1'b0;
      in_pull    = '0;
      case (state)
         ST_IDLE: begin
            if (found_c) begin
               state_nxt = ST_BUSY;
               grant_nxt = winner_c;
               count_nxt = count_arr[winner_c];
               // A zero-length header still carries one word
               if (count_arr[winner_c] == '0) begin
                  rem_nxt = REM_W'(1);
               end else begin
                  rem_nxt = {1'b0, count_arr[winner_c]};
               end
            end
         end
         ST_BUSY: begin
            strm_avail = in_avail[grant] & ~rst;
            if (strm_avail && strm_pull) begin
               in_pull[grant] = 1'b1;
               rem_nxt        = remaining - REM_W'(1);
               if (remaining == REM_W'(1)) begin
                  state_nxt = ST_IDLE;
                  last_nxt  = grant;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         grant      <= '0;
         last_grant <= LAST_RST;
         remaining  <= '0;
         strm_count <= '0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_nxt;
         remaining  <= rem_nxt;
         strm_count <= count_nxt;
      end
   end

   assign strm_id   = 4'(grant);
   assign strm_data = data_arr[grant];

endmodule

// File: tb/tb_streamselect_arb.sv
// Directed bench for streamselect_arb: a fixed-priority instance and a round-robin instance.
module tb_streamselect_arb;

   localparam int unsigned NS = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NS*DW-1:0] in_data;
   logic [NS*CW-1:0] cnt_rr, cnt_fp;
   logic [NS-1:0]    av_rr, av_fp, ip_rr, ip_fp;
   logic [DW-1:0]    sd_rr, sd_fp;
   logic [CW-1:0]    sc_rr, sc_fp;
   logic [3:0]       id_rr, id_fp;
   logic             sa_rr, sa_fp, sp_rr, sp_fp;

   streamselect_arb #(.NUM_STREAMS(NS), .DATA_W(DW), .COUNT_W(CW), .ROUND_ROBIN(1)) u_rr (
      .clk(clk), .rst(rst), .in_data(in_data), .in_count(cnt_rr), .in_avail(av_rr),
      .in_pull(ip_rr), .strm_data(sd_rr), .strm_count(sc_rr), .strm_id(id_rr),
      .strm_avail(sa_rr), .strm_pull(sp_rr));

   streamselect_arb #(.NUM_STREAMS(NS), .DATA_W(DW), .COUNT_W(CW), .ROUND_ROBIN(0)) u_fp (
      .clk(clk), .rst(rst), .in_data(in_data), .in_count(cnt_fp), .in_avail(av_fp),
      .in_pull(ip_fp), .strm_data(sd_fp), .strm_count(sc_fp), .strm_id(id_fp),
      .strm_avail(sa_fp), .strm_pull(sp_fp));

   typedef struct {
      logic       sel;       // 1 = round-robin instance
      logic [3:0] avail;
      logic       pull;
      logic       e_av;
      logic [3:0] e_pl;
      logic [3:0] e_id;
      logic [7:0] e_ct;
   } vec_t;

   vec_t vecs [15];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [DW-1:0] chan_data(input logic [3:0] id);
      return 32'hC0DE_0000 + 32'(id);
   endfunction

   task automatic chk(input string name, input logic sel, input logic e_av,
                      input logic [3:0] e_pl, input logic [3:0] e_id, input logic [7:0] e_ct);
      logic       a_av;
      logic [3:0] a_pl, a_id;
      logic [7:0] a_ct;
      logic [31:0] a_d, e_d;
      if (sel) begin
         a_av = sa_rr; a_pl = ip_rr; a_id = id_rr; a_ct = sc_rr; a_d = sd_rr;
      end else begin
         a_av = sa_fp; a_pl = ip_fp; a_id = id_fp; a_ct = sc_fp; a_d = sd_fp;
      end
      e_d = chan_data(e_id);
      n_checks++;
      if ({a_av, a_pl, a_id, a_ct, a_d} !== {e_av, e_pl, e_id, e_ct, e_d}) begin
         n_fail++;
         $display("FAIL %s: got avail=%0b pull=%b id=%0d count=%0d data=%h; required avail=%0b pull=%b id=%0d count=%0d data=%h",
                  name, a_av, a_pl, a_id, a_ct, a_d, e_av, e_pl, e_id, e_ct, e_d);
      end
   endtask

   // One clock: inputs change just after the rising edge, outputs are checked at the falling edge
   task automatic cyc(input logic sel, input logic r, input logic [3:0] av, input logic pl);
      @(posedge clk);
      #1;
      rst = r;
      if (sel) begin
         av_rr = av; sp_rr = pl; av_fp = '0; sp_fp = 1'b0;
      end else begin
         av_fp = av; sp_fp = pl; av_rr = '0; sp_rr = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("reset_rr", 1'b1, 1'b0, 4'b0000, 4'd0, 8'd0);
      chk("reset_fp", 1'b0, 1'b0, 4'b0000, 4'd0, 8'd0);
   endtask

   task automatic set_cnt(input logic sel, input int ch, input logic [7:0] v);
      if (sel) cnt_rr[ch*CW +: CW] = v;
      else     cnt_fp[ch*CW +: CW] = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int npull;
      rst = 1'b1;
      av_rr = '0; av_fp = '0; sp_rr = 1'b0; sp_fp = 1'b0;
      cnt_rr = '0; cnt_fp = '0;
      for (int i = 0; i < NS; i++) begin
         in_data[i*DW +: DW] = chan_data(4'(i));
         cnt_rr[i*CW +: CW]  = 8'd1;
      end
      set_cnt(1'b0, 1, 8'd2);
      set_cnt(1'b0, 3, 8'd1);

      // Fixed priority, avail 1010 held: ch1 twice in a row, never ch3
      vecs[0]  = '{1'b0, 4'b1010, 1'b1, 1'b0, 4'b0000, 4'd0, 8'd0};
      vecs[1]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 4'd1, 8'd2};
      vecs[2]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 4'd1, 8'd2};
      vecs[3]  = '{1'b0, 4'b1010, 1'b1, 1'b0, 4'b0000, 4'd1, 8'd2};
      vecs[4]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 4'd1, 8'd2};
      // Round-robin, all avail, count 1: grants 0,1,2,3,0 with a bubble between
      vecs[5]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'd0, 8'd0};
      vecs[6]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 4'd0, 8'd1};
      vecs[7]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'd0, 8'd1};
      vecs[8]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0010, 4'd1, 8'd1};
      vecs[9]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'd1, 8'd1};
      vecs[10] = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0100, 4'd2, 8'd1};
      vecs[11] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'd2, 8'd1};
      vecs[12] = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b1000, 4'd3, 8'd1};
      vecs[13] = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'd3, 8'd1};
      vecs[14] = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 4'd0, 8'd1};

      for (int i = 0; i < 15; i++) begin
         if (i == 0 || i == 5) do_reset();
         cyc(vecs[i].sel, 1'b0, vecs[i].avail, vecs[i].pull);
         chk($sformatf("vec%0d", i), vecs[i].sel, vecs[i].e_av, vecs[i].e_pl, vecs[i].e_id, vecs[i].e_ct);
      end

      // Stall: granted ch2 drops avail for 5 cycles while ch0 waits
      do_reset();
      set_cnt(1'b1, 2, 8'd3);
      set_cnt(1'b1, 0, 8'd1);
      cyc(1'b1, 1'b0, 4'b0100, 1'b0); chk("stall_idle", 1'b1, 1'b0, 4'b0000, 4'd0, 8'd0);
      cyc(1'b1, 1'b0, 4'b0100, 1'b1); chk("stall_pull1", 1'b1, 1'b1, 4'b0100, 4'd2, 8'd3);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 1'b0, 4'b0001, 1'b1);
         chk($sformatf("stall_hold%0d", k), 1'b1, 1'b0, 4'b0000, 4'd2, 8'd3);
      end
      cyc(1'b1, 1'b0, 4'b0101, 1'b1); chk("stall_pull2", 1'b1, 1'b1, 4'b0100, 4'd2, 8'd3);
      cyc(1'b1, 1'b0, 4'b0101, 1'b1); chk("stall_pull3", 1'b1, 1'b1, 4'b0100, 4'd2, 8'd3);
      cyc(1'b1, 1'b0, 4'b0101, 1'b1); chk("stall_bubble", 1'b1, 1'b0, 4'b0000, 4'd2, 8'd3);
      cyc(1'b1, 1'b0, 4'b0101, 1'b1); chk("stall_ch0", 1'b1, 1'b1, 4'b0001, 4'd0, 8'd1);

      // Length extremes: count 0 takes one pull, count 255 takes 255 pulls
      do_reset();
      set_cnt(1'b1, 0, 8'd0);
      set_cnt(1'b1, 1, 8'd255);
      cyc(1'b1, 1'b0, 4'b0011, 1'b1); chk("len_idle", 1'b1, 1'b0, 4'b0000, 4'd0, 8'd0);
      cyc(1'b1, 1'b0, 4'b0011, 1'b1); chk("len_zero", 1'b1, 1'b1, 4'b0001, 4'd0, 8'd0);
      cyc(1'b1, 1'b0, 4'b0011, 1'b1); chk("len_zero_done", 1'b1, 1'b0, 4'b0000, 4'd0, 8'd0);
      npull = 0;
      for (int k = 0; k < 300; k++) begin
         cyc(1'b1, 1'b0, 4'b0011, 1'b1);
         if (k == 10) set_cnt(1'b1, 1, 8'd5);
         if (ip_rr == 4'b0010 && id_rr == 4'd1 && sc_rr == 8'd255) npull++;
         else break;
      end
      n_checks++;
      if (npull != 255) begin
         n_fail++;
         $display("FAIL len_max_pulls: got %0d pulls, required 255", npull);
      end
      chk("len_max_bubble", 1'b1, 1'b0, 4'b0000, 4'd1, 8'd255);
      cyc(1'b1, 1'b0, 4'b0011, 1'b1); chk("len_next_ch0", 1'b1, 1'b1, 4'b0001, 4'd0, 8'd0);

      // Reset mid-message aborts it and restarts round-robin at ch0
      do_reset();
      set_cnt(1'b1, 0, 8'd1);
      set_cnt(1'b1, 3, 8'd4);
      cyc(1'b1, 1'b0, 4'b0001, 1'b1); chk("mid_idle", 1'b1, 1'b0, 4'b0000, 4'd0, 8'd0);
      cyc(1'b1, 1'b0, 4'b0001, 1'b1); chk("mid_ch0", 1'b1, 1'b1, 4'b0001, 4'd0, 8'd1);
      cyc(1'b1, 1'b0, 4'b1000, 1'b1); chk("mid_bubble", 1'b1, 1'b0, 4'b0000, 4'd0, 8'd1);
      cyc(1'b1, 1'b0, 4'b1000, 1'b1); chk("mid_ch3_pull1", 1'b1, 1'b1, 4'b1000, 4'd3, 8'd4);
      cyc(1'b1, 1'b1, 4'b1001, 1'b1); chk("mid_rst_cycle", 1'b1, 1'b0, 4'b0000, 4'd3, 8'd4);
      cyc(1'b1, 1'b0, 4'b1001, 1'b1); chk("mid_after_rst", 1'b1, 1'b0, 4'b0000, 4'd0, 8'd0);
      cyc(1'b1, 1'b0, 4'b1001, 1'b1); chk("mid_rr_restart", 1'b1, 1'b1, 4'b0001, 4'd0, 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
